wbarbiter_nm: RTL and testbench

N-master Wishbone (pipelined) arbiter with a registered grant, selectable round-robin or fixed-priority arbitration, and outstanding-request tracking. A per-transaction ack timeout recovers the bus from a hung slave. It sits between the AXI-Lite-to-WB bridge(s), the debug/config masters and the shared WB slave fabric. It replaces the two-master combinational arbiter where more than two masters exist.

---
 rtl/wbarbiter_nm.sv | 171 +++++++++++++++++
 tb/tb_wbarbiter_nm.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbarbiter_nm.sv
// N-master pipelined Wishbone arbiter with registered one-hot grant, round-robin or
// fixed-priority selection, outstanding-request tracking and an ack timeout abort.
module wbarbiter_nm #(
    parameter int    NM               = 4,
    parameter int    DW               = 32,
    parameter int    AW               = 32,
    parameter string SCHEME           = "ROUND_ROBIN",
    parameter int    LGDEPTH          = 3,
    parameter int    TIMEOUT          = 64,
    parameter bit    OPT_ZERO_ON_IDLE = 1'b0
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic [NM-1:0]          i_cyc,
    input  logic [NM-1:0]          i_stb,
    input  logic [NM-1:0]          i_we,
    input  logic [NM*AW-1:0]       i_adr,
    input  logic [NM*DW-1:0]       i_dat,
    input  logic [NM*(DW/8)-1:0]   i_sel,
    output logic [NM-1:0]          o_ack,
    output logic [NM-1:0]          o_stall,
    output logic [NM-1:0]          o_err,
    output logic                   o_cyc,
    output logic                   o_stb,
    output logic                   o_we,
    output logic [AW-1:0]          o_adr,
    output logic [DW-1:0]          o_dat,
    output logic [DW/8-1:0]        o_sel,
    input  logic                   i_ack,
    input  logic                   i_stall,
    input  logic                   i_err,
    output logic [NM-1:0]          o_grant,
    output logic                   o_timeout
);

    localparam int LGNM = (NM > 1) ? $clog2(NM) : 1;
    localparam int SW   = DW / 8;
    localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit USE_RR = (SCHEME == "ROUND_ROBIN");

    typedef enum logic [1:0] {S_IDLE, S_OWNED, S_ABORT} state_t;

    state_t              state;
    logic [NM-1:0]       grant;
    logic [LGNM-1:0]     owner;
    logic [LGNM-1:0]     rr;
    logic [LGDEPTH-1:0]  outstanding;
    logic [TW-1:0]       timer;

    logic [NM-1:0]       req;
    logic [LGNM-1:0]     winner;
    logic                owned;
    logic                own_cyc;
    logic                full;
    logic                rsp;
    logic                stb_out;
    logic                accept;
    logic                fire;

    // Round-robin searches upward from the last winner; the descending loop lets the
    // closest requester overwrite farther ones.
    function automatic logic [LGNM-1:0] pick(input logic [NM-1:0] r,
                                             input logic [LGNM-1:0] last);
        logic [LGNM-1:0] w;
        int idx;
        w = '0;
        if (USE_RR) begin
            for (int i = NM; i >= 1; i--) begin
                idx = (int'(last) + i) % NM;
                if (r[idx]) w = LGNM'(idx);
            end
        end else begin
            for (int i = NM - 1; i >= 0; i--) begin
                if (r[i]) w = LGNM'(i);
            end
        end
        return w;
    endfunction

    assign req     = i_cyc & i_stb;
    assign winner  = pick(req, rr);
    assign owned   = (state == S_OWNED);
    assign own_cyc = i_cyc[owner];
    assign full    = &outstanding;
    assign rsp     = i_ack | i_err;
    assign stb_out = owned & own_cyc & i_stb[owner] & ~full;
    assign accept  = stb_out & ~i_stall;
    assign fire    = (TIMEOUT != 0) && owned && own_cyc && (outstanding != '0)
                     && (timer == TO_LAST) && !rsp && !accept;

    always_comb begin
        o_cyc     = owned & own_cyc;
        o_stb     = stb_out;
        o_we      = 1'b0;
        o_adr     = '0;
        o_dat     = '0;
        o_sel     = '0;
        o_stall   = '1;
        o_ack     = '0;
        o_err     = '0;
        o_timeout = fire;
        o_grant   = grant;
        if (owned || !OPT_ZERO_ON_IDLE) begin
            o_we  = i_we[owner];
            o_adr = i_adr[int'(owner)*AW +: AW];
            o_dat = i_dat[int'(owner)*DW +: DW];
            o_sel = i_sel[int'(owner)*SW +: SW];
        end
        if (owned) begin
            o_stall[owner] = i_stall | full;
            o_ack[owner]   = i_ack;
            o_err[owner]   = i_err | fire;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= S_IDLE;
            grant       <= '0;
            owner       <= '0;
            rr          <= LGNM'(NM - 1);
            outstanding <= '0;
            timer       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        state       <= S_OWNED;
                        grant       <= NM'(1) << winner;
                        owner       <= winner;
                        outstanding <= '0;
                        timer       <= '0;
                        if (USE_RR) rr <= winner;
                    end
                end
                S_OWNED: begin
                    if (!own_cyc) begin
                        // Release abandons any acks still in flight.
                        state       <= S_IDLE;
                        grant       <= '0;
                        outstanding <= '0;
                        timer       <= '0;
                    end else if (fire) begin
                        state <= S_ABORT;
                    end else begin
                        case ({accept, rsp})
                            2'b10:   outstanding <= outstanding + 1'b1;
                            2'b01:   if (outstanding != '0) outstanding <= outstanding - 1'b1;
                            default: ;
                        endcase
                        if (accept || rsp)
                            timer <= '0;
                        else if (outstanding != '0)
                            timer <= timer + 1'b1;
                    end
                end
                S_ABORT: begin
                    if (!own_cyc) begin
                        state       <= S_IDLE;
                        grant       <= '0;
                        outstanding <= '0;
                        timer       <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wbarbiter_nm.sv
// Bench for wbarbiter_nm: a round-robin and a priority instance share stimulus and are
// both checked every cycle against a transaction-level model, plus directed sequences.
module tb_wbarbiter_nm;

    localparam int NM  = 4;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int SW  = DW / 8;
    localparam int LGD = 2;
    localparam int TMO = 8;
    localparam int CAP = (1 << LGD) - 1;

    logic              i_clk = 1'b0;
    logic              i_reset_n;
    logic [NM-1:0]     m_cyc, m_stb, m_we;
    logic [NM*AW-1:0]  m_adr;
    logic [NM*DW-1:0]  m_dat;
    logic [NM*SW-1:0]  m_sel;
    logic              s_ack, s_stall, s_err;

    logic [NM-1:0]     ack [2];
    logic [NM-1:0]     stall [2];
    logic [NM-1:0]     err [2];
    logic [NM-1:0]     grant [2];
    logic              cyc [2];
    logic              stb [2];
    logic              we [2];
    logic              tmo [2];
    logic [AW-1:0]     adr [2];
    logic [DW-1:0]     dat [2];
    logic [SW-1:0]     sel [2];

    int n_vec = 0;
    int n_bad = 0;

    // model state: owner index (-1 when nobody owns the bus), abort flag, outstanding
    // transfers, cycles waited without response, last round-robin winner
    int m_owner [2], m_outs [2], m_wait [2], m_rr [2];
    bit m_abort [2];
    int n_owner [2], n_outs [2], n_wait [2], n_rr [2];
    bit n_abort [2];

    typedef struct {
        logic [NM-1:0] c, s;
        logic          a;
        logic [NM-1:0] g;
        logic          oc, os;
        logic [NM-1:0] oa, ost;
    } vec_t;
    vec_t tbl [$];

    always #5 i_clk = ~i_clk;

    wbarbiter_nm #(.NM(NM), .DW(DW), .AW(AW), .SCHEME("ROUND_ROBIN"), .LGDEPTH(LGD),
                   .TIMEOUT(TMO), .OPT_ZERO_ON_IDLE(1'b1)) u_rr (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_cyc(m_cyc), .i_stb(m_stb), .i_we(m_we), .i_adr(m_adr), .i_dat(m_dat), .i_sel(m_sel),
        .o_ack(ack[0]), .o_stall(stall[0]), .o_err(err[0]),
        .o_cyc(cyc[0]), .o_stb(stb[0]), .o_we(we[0]), .o_adr(adr[0]), .o_dat(dat[0]), .o_sel(sel[0]),
        .i_ack(s_ack), .i_stall(s_stall), .i_err(s_err),
        .o_grant(grant[0]), .o_timeout(tmo[0]));

    wbarbiter_nm #(.NM(NM), .DW(DW), .AW(AW), .SCHEME("PRIORITY"), .LGDEPTH(LGD),
                   .TIMEOUT(TMO), .OPT_ZERO_ON_IDLE(1'b1)) u_pr (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_cyc(m_cyc), .i_stb(m_stb), .i_we(m_we), .i_adr(m_adr), .i_dat(m_dat), .i_sel(m_sel),
        .o_ack(ack[1]), .o_stall(stall[1]), .o_err(err[1]),
        .o_cyc(cyc[1]), .o_stb(stb[1]), .o_we(we[1]), .o_adr(adr[1]), .o_dat(dat[1]), .o_sel(sel[1]),
        .i_ack(s_ack), .i_stall(s_stall), .i_err(s_err),
        .o_grant(grant[1]), .o_timeout(tmo[1]));

    task automatic chk(input string name, input int d, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d at %0t: got %0h, expected %0h", name, d, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = -1; m_abort[d] = 1'b0; m_outs[d] = 0; m_wait[d] = 0; m_rr[d] = NM - 1;
        end
    endtask

    task automatic model_check();
        for (int d = 0; d < 2; d++) begin
            int g, w;
            bit found, full, acc, fire, rspv;
            logic [NM-1:0] reqs, e_grant, e_stall, e_ack, e_err;
            logic e_cyc, e_stb, e_we, e_tmo;
            logic [AW-1:0] e_adr;
            logic [DW-1:0] e_dat;
            logic [SW-1:0] e_sel;
            g = m_owner[d];
            rspv = s_ack | s_err;
            e_grant = '0; e_stall = '1; e_ack = '0; e_err = '0;
            e_cyc = 0; e_stb = 0; e_we = 0; e_tmo = 0; e_adr = '0; e_dat = '0; e_sel = '0;
            n_owner[d] = m_owner[d]; n_abort[d] = m_abort[d]; n_outs[d] = m_outs[d];
            n_wait[d] = m_wait[d]; n_rr[d] = m_rr[d];
            if (g >= 0) e_grant = NM'(1) << g;
            if (g >= 0 && !m_abort[d]) begin
                full  = (m_outs[d] == CAP);
                e_cyc = m_cyc[g];
                e_stb = m_cyc[g] & m_stb[g] & !full;
                e_we  = m_we[g];
                e_adr = m_adr[g*AW +: AW];
                e_dat = m_dat[g*DW +: DW];
                e_sel = m_sel[g*SW +: SW];
                acc   = e_stb & !s_stall;
                fire  = m_cyc[g] && m_outs[d] > 0 && m_wait[d] == TMO - 1 && !rspv && !acc;
                e_stall[g] = s_stall | full;
                e_ack[g]   = s_ack;
                e_err[g]   = s_err | fire;
                e_tmo      = fire;
                if (!m_cyc[g]) begin
                    n_owner[d] = -1; n_outs[d] = 0; n_wait[d] = 0;
                end else if (fire) begin
                    n_abort[d] = 1'b1;
                end else begin
                    if (acc && !rspv) n_outs[d] = m_outs[d] + 1;
                    else if (!acc && rspv && m_outs[d] > 0) n_outs[d] = m_outs[d] - 1;
                    if (acc || rspv) n_wait[d] = 0;
                    else if (m_outs[d] > 0) n_wait[d] = m_wait[d] + 1;
                end
            end else if (g >= 0) begin
                if (!m_cyc[g]) begin
                    n_owner[d] = -1; n_abort[d] = 1'b0; n_outs[d] = 0; n_wait[d] = 0;
                end
            end else begin
                reqs = m_cyc & m_stb;
                found = 0; w = 0;
                for (int i = 0; i < NM; i++) begin
                    int k;
                    k = (d == 0) ? (m_rr[d] + 1 + i) % NM : i;
                    if (!found && reqs[k]) begin found = 1; w = k; end
                end
                if (found) begin
                    n_owner[d] = w; n_outs[d] = 0; n_wait[d] = 0;
                    if (d == 0) n_rr[d] = w;
                end
            end
            chk("grant", d, grant[d], e_grant);
            chk("o_cyc", d, cyc[d], e_cyc);
            chk("o_stb", d, stb[d], e_stb);
            chk("o_we", d, we[d], e_we);
            chk("o_adr", d, adr[d], e_adr);
            chk("o_dat", d, dat[d], e_dat);
            chk("o_sel", d, sel[d], e_sel);
            chk("o_stall", d, stall[d], e_stall);
            chk("o_ack", d, ack[d], e_ack);
            chk("o_err", d, err[d], e_err);
            chk("o_timeout", d, tmo[d], e_tmo);
        end
    endtask

    // Called at the falling edge with inputs already driven; returns at the next one.
    task automatic tick();
        #2;
        if (!i_reset_n) model_reset();
        model_check();
        @(posedge i_clk);
        m_owner = n_owner; m_abort = n_abort; m_outs = n_outs; m_wait = n_wait; m_rr = n_rr;
        if (!i_reset_n) model_reset();
        @(negedge i_clk);
    endtask

    task automatic rand_data();
        m_we = NM'($urandom);
        for (int k = 0; k < NM; k++) begin
            m_adr[k*AW +: AW] = AW'($urandom);
            m_dat[k*DW +: DW] = DW'($urandom);
            m_sel[k*SW +: SW] = SW'($urandom);
        end
    endtask

    task automatic rand_cycle(input int pa, input int pe, input int ps, input int pst);
        for (int k = 0; k < NM; k++) begin
            if (m_cyc[k]) begin
                if ($urandom_range(0, 15) == 0) m_cyc[k] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                m_cyc[k] = 1'b1;
            end
            m_stb[k] = m_cyc[k] & (int'($urandom_range(0, 99)) < pst);
        end
        rand_data();
        s_ack     = int'($urandom_range(0, 99)) < pa;
        s_err     = int'($urandom_range(0, 99)) < pe;
        s_stall   = int'($urandom_range(0, 99)) < ps;
        i_reset_n = ($urandom_range(0, 499) != 0);
        tick();
    endtask

    task automatic add(input logic [3:0] c, input logic [3:0] s, input logic a,
                       input logic [3:0] g, input logic oc, input logic os,
                       input logic [3:0] oa, input logic [3:0] ost);
        vec_t v;
        v.c = c; v.s = s; v.a = a; v.g = g; v.oc = oc; v.os = os; v.oa = oa; v.ost = ost;
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // single request from master 2, then master 1 filling the pipeline (depth 3)
        add(4'h4, 4'h4, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'hF);
        add(4'h4, 4'h4, 1'b0, 4'h4, 1'b1, 1'b1, 4'h0, 4'hB);
        add(4'h4, 4'h0, 1'b0, 4'h4, 1'b1, 1'b0, 4'h0, 4'hB);
        add(4'h4, 4'h0, 1'b1, 4'h4, 1'b1, 1'b0, 4'h4, 4'hB);
        add(4'h0, 4'h0, 1'b0, 4'h4, 1'b0, 1'b0, 4'h0, 4'hB);
        add(4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'hF);
        add(4'h2, 4'h2, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'hF);
        add(4'h2, 4'h2, 1'b0, 4'h2, 1'b1, 1'b1, 4'h0, 4'hD);
        add(4'h2, 4'h2, 1'b0, 4'h2, 1'b1, 1'b1, 4'h0, 4'hD);
        add(4'h2, 4'h2, 1'b0, 4'h2, 1'b1, 1'b1, 4'h0, 4'hD);
        add(4'h2, 4'h2, 1'b0, 4'h2, 1'b1, 1'b0, 4'h0, 4'hF);
        add(4'h2, 4'h2, 1'b1, 4'h2, 1'b1, 1'b0, 4'h2, 4'hF);
        add(4'h2, 4'h2, 1'b0, 4'h2, 1'b1, 1'b1, 4'h0, 4'hD);
        add(4'h2, 4'h2, 1'b1, 4'h2, 1'b1, 1'b0, 4'h2, 4'hF);
        add(4'h2, 4'h2, 1'b1, 4'h2, 1'b1, 1'b1, 4'h2, 4'hD);
        add(4'h2, 4'h2, 1'b0, 4'h2, 1'b1, 1'b1, 4'h0, 4'hD);
        add(4'h2, 4'h0, 1'b0, 4'h2, 1'b1, 1'b0, 4'h0, 4'hF);
        add(4'h2, 4'h0, 1'b1, 4'h2, 1'b1, 1'b0, 4'h2, 4'hF);
        add(4'h2, 4'h0, 1'b1, 4'h2, 1'b1, 1'b0, 4'h2, 4'hD);
        add(4'h2, 4'h0, 1'b1, 4'h2, 1'b1, 1'b0, 4'h2, 4'hD);
        add(4'h2, 4'h0, 1'b1, 4'h2, 1'b1, 1'b0, 4'h2, 4'hD);
        add(4'h2, 4'h2, 1'b0, 4'h2, 1'b1, 1'b1, 4'h0, 4'hD);
        add(4'h2, 4'h2, 1'b0, 4'h2, 1'b1, 1'b1, 4'h0, 4'hD);
        add(4'h2, 4'h2, 1'b0, 4'h2, 1'b1, 1'b1, 4'h0, 4'hD);
        add(4'h2, 4'h2, 1'b0, 4'h2, 1'b1, 1'b0, 4'h0, 4'hF);
        add(4'h0, 4'h0, 1'b0, 4'h2, 1'b0, 1'b0, 4'h0, 4'hF);
        add(4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'hF);

        i_reset_n = 1'b0;
        m_cyc = '0; m_stb = '0;
        s_ack = 1'b0; s_stall = 1'b0; s_err = 1'b0;
        rand_data();
        model_reset();
        @(negedge i_clk);
        #1;
        chk("reset grant", 0, grant[0], 4'h0);
        chk("reset stall", 0, stall[0], 4'hF);
        chk("reset cyc", 0, cyc[0], 1'b0);
        tick();
        i_reset_n = 1'b1;

        foreach (tbl[r]) begin
            m_cyc = tbl[r].c; m_stb = tbl[r].s; s_ack = tbl[r].a;
            #1;
            chk($sformatf("tbl%0d grant", r), 0, grant[0], tbl[r].g);
            chk($sformatf("tbl%0d o_cyc", r), 0, cyc[0], tbl[r].oc);
            chk($sformatf("tbl%0d o_stb", r), 0, stb[0], tbl[r].os);
            chk($sformatf("tbl%0d o_ack", r), 0, ack[0], tbl[r].oa);
            chk($sformatf("tbl%0d o_stall", r), 0, stall[0], tbl[r].ost);
            chk($sformatf("tbl%0d o_err", r), 0, err[0], 4'h0);
            tick();
        end
        s_ack = 1'b0;

        // timeout: master 3 gets one transfer accepted and the slave never answers
        m_cyc = 4'h8; m_stb = 4'h8;
        tick();
        tick();
        m_stb = 4'h0;
        for (int k = 1; k <= TMO; k++) begin
            #1;
            chk($sformatf("tmo wait%0d err", k), 0, err[0], (k == TMO) ? 4'h8 : 4'h0);
            chk($sformatf("tmo wait%0d pulse", k), 0, tmo[0], k == TMO);
            tick();
        end
        s_ack = 1'b1;
        #1;
        chk("abort cyc", 0, cyc[0], 1'b0);
        chk("abort late ack", 0, ack[0], 4'h0);
        chk("abort stall", 0, stall[0], 4'hF);
        tick();
        s_ack = 1'b0;
        tick();
        m_cyc = 4'h0;
        #1;
        chk("abort grant held", 0, grant[0], 4'h8);
        tick();
        chk("abort to idle", 0, grant[0], 4'h0);

        // fairness: every master requests continuously and leaves after one ack
        m_cyc = 4'hF; m_stb = 4'hF;
        for (int n = 0; n < 5; n++) begin
            int b, g;
            b = 0;
            g = n % NM;
            while (grant[0] == 4'h0 && b < 8) begin
                tick();
                b++;
            end
            chk($sformatf("rr order %0d", n), 0, grant[0], NM'(1) << g);
            s_ack = 1'b1;
            tick();
            s_ack = 1'b0;
            m_cyc[g] = 1'b0; m_stb[g] = 1'b0;
            tick();
            m_cyc[g] = 1'b1; m_stb[g] = 1'b1;
        end

        // scheme difference: masters 0 and 2 request from idle, last RR winner was 0
        m_cyc = 4'h0; m_stb = 4'h0;
        tick(); tick(); tick();
        m_cyc = 4'h5; m_stb = 4'h5;
        tick();
        chk("rr picks 2", 0, grant[0], 4'h4);
        chk("prio picks 0", 1, grant[1], 4'h1);

        // reset in the middle of a burst with two transfers outstanding
        tick(); tick();
        #1;
        i_reset_n = 1'b0;
        #1;
        chk("midreset cyc", 0, cyc[0], 1'b0);
        chk("midreset grant", 0, grant[0], 4'h0);
        chk("midreset stall", 0, stall[0], 4'hF);
        chk("midreset grant", 1, grant[1], 4'h0);
        model_reset();
        tick();
        i_reset_n = 1'b1;
        m_cyc = 4'hF; m_stb = 4'hF;
        tick();
        chk("post-reset rr start", 0, grant[0], 4'h1);

        m_cyc = 4'h0; m_stb = 4'h0;
        for (int i = 0; i < 800; i++) rand_cycle(30, 5, 25, 60);
        for (int i = 0; i < 800; i++) rand_cycle(3, 0, 50, 20);
        for (int i = 0; i < 800; i++) rand_cycle(50, 10, 10, 90);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
